// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: loadable program memory plus a sequencer that drives Din/run of the core.
// Optional done watchdog compiled in when FETCH_TIMEOUT_EN is defined (adds DONE_TIMEOUT).
module instr_fetch_unit #(
  parameter int         ADDR_W      = 6,
  parameter int         DATA_W      = 16,
  parameter logic [3:0] MVI_OPCODE  = 4'b0001,
  parameter logic [3:0] HALT_OPCODE = 4'b1111
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int         DONE_TIMEOUT = 255
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              done,
  output logic [DATA_W-1:0] Din,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, IMM, WAIT, HALTED} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] fetch_word;
  logic [ADDR_W-1:0] pc_inc;
  logic              idle_like;
  logic              is_mvi;
  logic              done_seen;
  logic              wait_expired;

  assign idle_like  = (state == IDLE) || (state == HALTED);
  assign fetch_word = mem[pc];
  assign pc_inc     = pc + ADDR_W'(1);
  assign is_mvi     = (Din[DATA_W-1 -: 4] == MVI_OPCODE);

  // NOTE: the program memory is deliberately left out of reset; only its write port is clocked.
  always_ff @(posedge clock) begin
    if (load_en && idle_like) mem[load_addr] <= load_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned (no inferred latch).
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   next_state = (fetch_word[DATA_W-1 -: 4] == HALT_OPCODE) ? HALTED : ISSUE;
      ISSUE:   next_state = is_mvi ? IMM : WAIT;
      IMM:     next_state = WAIT;
      WAIT: begin
        if (done || done_seen) next_state = FETCH;
        else if (wait_expired) next_state = HALTED;
      end
      HALTED:  if (start) next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    run    = 1'b0;
    busy   = 1'b1;
    halted = 1'b0;
    case (state)
      ISSUE:   run = 1'b1;
      IDLE:    busy = 1'b0;
      HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  // The immediate is preloaded at the end of ISSUE so the core sees it during IMM;
  // IMM reloads the same word (the memory cannot change while busy).
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= '0;
      Din       <= '0;
      done_seen <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: if (start) pc <= '0;
        FETCH:        Din <= fetch_word;
        ISSUE: begin
          pc <= pc_inc;
          if (is_mvi) Din <= mem[pc_inc];
        end
        IMM: begin
          Din <= fetch_word;
          pc  <= pc_inc;
          if (done) done_seen <= 1'b1;
        end
        WAIT:         if (done || done_seen) done_seen <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(DONE_TIMEOUT + 1) > 8) ? $clog2(DONE_TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;

  // Counts completed WAIT cycles without done; the DONE_TIMEOUT-th one expires.
  assign wait_expired = (state == WAIT) && !done && !done_seen &&
                        (wait_cnt == CNT_W'(DONE_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != WAIT) wait_cnt <= '0;
      else if (!done)    wait_cnt <= wait_cnt + 1'b1;
      if (state == HALTED && start) timeout_err <= 1'b0;
      else if (wait_expired)        timeout_err <= 1'b1;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed latency/boundary scenarios plus random programs
// checked against a program-level reference model of the fetch sequence.
module tb_instr_fetch_unit;
  localparam int         ADDR_W = 6;
  localparam int         DATA_W = 16;
  localparam int         DEPTH  = 2**ADDR_W;
  localparam logic [3:0] MVI    = 4'h1;
  localparam logic [3:0] HALT   = 4'hF;

  logic              clock = 1'b0;
  logic              reset, start, load_en, done;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] Din;
  logic              run, busy, halted, timeout_err;
  logic [ADDR_W-1:0] pc;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] instr;
    bit                is_mvi;
    logic [DATA_W-1:0] imm;
  } issue_t;

  issue_t exp_q[$];
  bit     exp_halt;
  int     exp_halt_addr;

  instr_fetch_unit #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef FETCH_TIMEOUT_EN
    , .DONE_TIMEOUT(4)
`endif
  ) dut (
    .clock(clock), .reset(reset), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .done(done),
    .Din(Din), .run(run), .pc(pc), .busy(busy), .halted(halted),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; load_en = 1'b0; done = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic load_word(input int a, input logic [DATA_W-1:0] d);
    load_en = 1'b1; load_addr = ADDR_W'(a); load_data = d; ref_mem[a] = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Program-level model: walk memory from 0 and list every issued instruction.
  function automatic void build_model(input int limit);
    int a = 0;
    exp_q.delete();
    exp_halt = 1'b0;
    exp_halt_addr = 0;
    while (exp_q.size() < limit) begin
      issue_t e;
      if (ref_mem[a][15:12] == HALT) begin
        exp_halt = 1'b1;
        exp_halt_addr = a;
        return;
      end
      e.addr   = ADDR_W'(a);
      e.instr  = ref_mem[a];
      e.is_mvi = (ref_mem[a][15:12] == MVI);
      e.imm    = '0;
      a = (a + 1) % DEPTH;
      if (e.is_mvi) begin
        e.imm = ref_mem[a];
        a = (a + 1) % DEPTH;
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; load_en = 1'b0; done = 1'b0;
    load_addr = '0; load_data = '0;
    step();
    total++; if (run !== 1'b0)  begin bad++; $display("FAIL reset_run: got %b want 0", run); end
    total++; if (pc !== '0)     begin bad++; $display("FAIL reset_pc: got %h want 0", pc); end
    total++; if (Din !== '0)    begin bad++; $display("FAIL reset_din: got %h want 0", Din); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mvi_basic();
    do_reset();
    load_word(0, 16'h1002); load_word(1, 16'h0005); load_word(2, 16'hF000);
    pulse_start();
    step();
    total++; if (run !== 1'b1) begin bad++; $display("FAIL mvi_run_latency: got %b want 1", run); end
    total++; if (Din !== 16'h1002) begin bad++; $display("FAIL mvi_instr: got %h want 1002", Din); end
    step();
    total++; if (run !== 1'b0) begin bad++; $display("FAIL mvi_run_width: got %b want 0", run); end
    total++; if (Din !== 16'h0005) begin bad++; $display("FAIL mvi_imm: got %h want 0005", Din); end
    step(); step();
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL mvi_early_halt: got %b want 0", halted); end
    step();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL mvi_halted: got %b want 1", halted); end
    total++; if (pc !== 6'd2) begin bad++; $display("FAIL mvi_halt_pc: got %0d want 2", pc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mvi_halt_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_word(0, 16'h2010); load_word(1, 16'h3020); load_word(2, 16'hF000);
    pulse_start();
    step();
    total++; if (run !== 1'b1 || Din !== 16'h2010) begin bad++; $display("FAIL b2b_first: got run=%b din=%h want run=1 din=2010", run, Din); end
    step(); done = 1'b1;
    step(); done = 1'b0;
    total++; if (run !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b want 0", run); end
    step();
    total++; if (run !== 1'b1 || Din !== 16'h3020) begin bad++; $display("FAIL b2b_second: got run=%b din=%h want run=1 din=3020", run, Din); end
    total++; if (pc !== 6'd1) begin bad++; $display("FAIL b2b_pc: got %0d want 1", pc); end
    step(); done = 1'b1;
    step(); done = 1'b0;
    step();
    total++; if (halted !== 1'b1 || pc !== 6'd2) begin bad++; $display("FAIL b2b_halt: got halted=%b pc=%0d want halted=1 pc=2", halted, pc); end
  endtask

  task automatic test_done_in_imm();
    do_reset();
    load_word(0, 16'h1234); load_word(1, 16'h00AB); load_word(2, 16'h2000); load_word(3, 16'hF000);
    pulse_start();
    step();
    step(); done = 1'b1;
    total++; if (Din !== 16'h00AB) begin bad++; $display("FAIL imm_value: got %h want 00ab", Din); end
    step(); done = 1'b0;
    step();
    total++; if (run !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL imm_fetch: got run=%b busy=%b want run=0 busy=1", run, busy); end
    step();
    total++; if (run !== 1'b1 || Din !== 16'h2000 || pc !== 6'd2) begin bad++; $display("FAIL imm_done_seen: got run=%b din=%h pc=%0d want run=1 din=2000 pc=2", run, Din, pc); end
    step(); done = 1'b1;
    step(); done = 1'b0;
    step();
    total++; if (halted !== 1'b1 || pc !== 6'd3) begin bad++; $display("FAIL imm_halt: got halted=%b pc=%0d want halted=1 pc=3", halted, pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_word(0, 16'h2010); load_word(1, 16'hF000);
    pulse_start();
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (run !== 1'b0 || pc !== '0 || Din !== '0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_state: got run=%b pc=%0d din=%h busy=%b want 0/0/0000/0", run, pc, Din, busy); end
    pulse_start();
    step();
    total++; if (run !== 1'b1 || Din !== 16'h2010 || pc !== '0) begin bad++; $display("FAIL midreset_restart: got run=%b din=%h pc=%0d want run=1 din=2010 pc=0", run, Din, pc); end
    step(); done = 1'b1;
    step(); done = 1'b0;
    step();
    total++; if (halted !== 1'b1 || pc !== 6'd1) begin bad++; $display("FAIL midreset_halt: got halted=%b pc=%0d want halted=1 pc=1", halted, pc); end
  endtask

  // From HALTED: a load and a start in the same cycle; the new word must be fetched.
  task automatic test_load_with_start();
    start = 1'b1;
    load_word(0, 16'h4444);
    start = 1'b0;
    step();
    total++; if (run !== 1'b1 || Din !== 16'h4444) begin bad++; $display("FAIL load_start: got run=%b din=%h want run=1 din=4444", run, Din); end
    do_reset();
  endtask

  task automatic test_random_programs();
    for (int p = 0; p < 8; p++) begin
      int  limit;
      bit  ok;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
        logic [3:0]        op;
        logic [DATA_W-1:0] w;
        op = 4'($urandom_range(2, 14));
        if (p != 0 && $urandom_range(0, 3) == 0) op = MVI;
        if (p == 0 && i == DEPTH - 1) op = MVI;
        w = {op, 12'($urandom)};
        load_word(i, w);
      end
      if (p != 0 && $urandom_range(0, 3) != 0) load_word($urandom_range(4, 40), {HALT, 12'($urandom)});
      limit = (p == 0) ? 66 : 30;
      build_model(limit);
      pulse_start();
      ok = 1'b1;
      for (int n = 0; n < exp_q.size() && ok; n++) begin
        issue_t            e;
        int                k;
        int                cyc;
        logic [ADDR_W-1:0] nxt;
        e = exp_q[n];
        nxt = e.addr + 1'b1;
        cyc = 0;
        while (!run && cyc < 12) begin step(); cyc++; end
        total++; if (run !== 1'b1) begin bad++; $display("FAIL rnd_run_timeout: prog %0d item %0d got run=%b want 1", p, n, run); ok = 1'b0; end
        if (ok) begin
          total++; if (Din !== e.instr || pc !== e.addr) begin bad++; $display("FAIL rnd_issue: prog %0d item %0d got din=%h pc=%0d want din=%h pc=%0d", p, n, Din, pc, e.instr, e.addr); end
          k = $urandom_range(1, 3);
          step();
          total++; if (run !== 1'b0 || pc !== nxt) begin bad++; $display("FAIL rnd_after_issue: prog %0d item %0d got run=%b pc=%0d want run=0 pc=%0d", p, n, run, pc, nxt); end
          if (e.is_mvi) begin
            total++; if (Din !== e.imm) begin bad++; $display("FAIL rnd_imm: prog %0d item %0d got %h want %h", p, n, Din, e.imm); end
          end
          for (int j = 1; j <= k; j++) begin
            if ($urandom_range(0, 2) == 0) begin
              start = 1'b1; load_en = 1'b1;
              load_addr = ADDR_W'($urandom); load_data = DATA_W'($urandom);
            end
            done = (j == k);
            step();
            start = 1'b0; load_en = 1'b0; done = 1'b0;
          end
        end
      end
      if (ok && exp_halt) begin
        int cyc = 0;
        while (!halted && cyc < 12) begin step(); cyc++; end
        total++; if (halted !== 1'b1 || pc !== ADDR_W'(exp_halt_addr) || busy !== 1'b0) begin bad++; $display("FAIL rnd_halt: prog %0d got halted=%b pc=%0d busy=%b want halted=1 pc=%0d busy=0", p, halted, pc, busy, exp_halt_addr); end
      end
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    load_word(0, 16'h2010);
    pulse_start();
    step();
    for (int j = 0; j < 4; j++) step();
    total++; if (halted !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_early: got halted=%b err=%b want 0/0", halted, timeout_err); end
    step();
    total++; if (halted !== 1'b1 || timeout_err !== 1'b1 || pc !== 6'd1) begin bad++; $display("FAIL to_fire: got halted=%b err=%b pc=%0d want 1/1/1", halted, timeout_err, pc); end
    pulse_start();
    total++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL to_clear: got err=%b busy=%b want 0/1", timeout_err, busy); end
    do_reset();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mvi_basic();
    test_back_to_back();
    test_done_in_imm();
    test_reset_mid();
    test_load_with_start();
    test_random_programs();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
